// File: rtl/rtc_bus_scheduler.sv
// RTC bus scheduler: arbitrates init / write / refresh requests and
// issues one register transaction at a time to the bus-cycle engine.
module rtc_bus_scheduler #(
    parameter logic [7:0] ADDR_SEG  = 8'h21,
    parameter logic [7:0] ADDR_TSEG = 8'h41,
    parameter logic [7:0] ADDR_CTRL = 8'h02,
    parameter logic [7:0] INIT_VAL1 = 8'h10,
    parameter logic [7:0] INIT_VAL2 = 8'h00,
    parameter int         TIMEOUT   = 1000
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       init_req,
    input  logic       wr_req,
    input  logic       ct_sel,
    input  logic       refresh_tick,
    input  logic [7:0] w_seg,
    input  logic [7:0] w_min,
    input  logic [7:0] w_hora,
    input  logic [7:0] w_dia,
    input  logic [7:0] w_mes,
    input  logic [7:0] w_ano,
    input  logic [7:0] w_tseg,
    input  logic [7:0] w_tmin,
    input  logic [7:0] w_thora,
    input  logic       bus_done,
    input  logic [7:0] rd_data,
    output logic       bus_start,
    output logic       bus_rw,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic [7:0] r_seg,
    output logic [7:0] r_min,
    output logic [7:0] r_hora,
    output logic [7:0] r_dia,
    output logic [7:0] r_mes,
    output logic [7:0] r_ano,
    output logic [7:0] r_tseg,
    output logic [7:0] r_tmin,
    output logic [7:0] r_thora,
    output logic       rd_valid,
    output logic       busy,
    output logic       bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT} state_t;
    typedef enum logic [1:0] {Q_INIT, Q_CLK, Q_TMR, Q_RD} seq_t;

    state_t         state_q, state_d;
    seq_t           seq_q, seq_d;
    logic [3:0]     idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           init_p_q, init_p_d;
    logic           wr_p_q, wr_p_d;
    logic           rd_p_q, rd_p_d;
    logic           wr_ct_q, wr_ct_d;
    logic           err_q, err_d;
    logic           rdv_q, rdv_d;
    logic           rw_q, rw_d;
    logic [7:0]     addr_q, addr_d;
    logic [7:0]     wdata_q, wdata_d;
    logic [7:0]     snap_q [9];
    logic [7:0]     snap_d [9];
    logic [7:0]     shad_q [9];
    logic [7:0]     shad_d [9];
    logic [7:0]     r_q [9];
    logic [7:0]     r_d [9];

    logic           item_rw;
    logic [7:0]     item_addr;
    logic [7:0]     item_wdata;
    logic [3:0]     last_idx;

    // Item decode for the current sequence position
    always_comb begin
        item_rw    = 1'b1;
        item_addr  = ADDR_CTRL;
        item_wdata = INIT_VAL1;
        last_idx   = 4'd1;
        unique case (seq_q)
            Q_INIT: begin
                item_wdata = (idx_q == 4'd0) ? INIT_VAL1 : INIT_VAL2;
            end
            Q_CLK: begin
                item_addr  = ADDR_SEG + {4'b0, idx_q};
                item_wdata = snap_q[idx_q];
                last_idx   = 4'd5;
            end
            Q_TMR: begin
                item_addr  = ADDR_TSEG + {4'b0, idx_q};
                item_wdata = snap_q[idx_q + 4'd6];
                last_idx   = 4'd2;
            end
            Q_RD: begin
                item_rw    = 1'b0;
                item_wdata = 8'h00;
                last_idx   = 4'd8;
                if (idx_q < 4'd6)
                    item_addr = ADDR_SEG + {4'b0, idx_q};
                else
                    item_addr = ADDR_TSEG + {4'b0, idx_q - 4'd6};
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        init_p_d = init_p_q;
        wr_p_d   = wr_p_q;
        rd_p_d   = rd_p_q;
        wr_ct_d  = wr_ct_q;
        err_d    = err_q;
        rdv_d    = 1'b0;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        snap_d   = snap_q;
        shad_d   = shad_q;
        r_d      = r_q;

        unique case (state_q)
            S_IDLE: begin
                if (init_p_q) begin
                    seq_d    = Q_INIT;
                    init_p_d = 1'b0;
                    idx_d    = 4'd0;
                    state_d  = S_ISSUE;
                end else if (wr_p_q) begin
                    seq_d     = wr_ct_q ? Q_CLK : Q_TMR;
                    wr_p_d    = 1'b0;
                    idx_d     = 4'd0;
                    state_d   = S_ISSUE;
                    snap_d[0] = w_seg;
                    snap_d[1] = w_min;
                    snap_d[2] = w_hora;
                    snap_d[3] = w_dia;
                    snap_d[4] = w_mes;
                    snap_d[5] = w_ano;
                    snap_d[6] = w_tseg;
                    snap_d[7] = w_tmin;
                    snap_d[8] = w_thora;
                end else if (rd_p_q) begin
                    seq_d   = Q_RD;
                    rd_p_d  = 1'b0;
                    idx_d   = 4'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                rw_d    = item_rw;
                addr_d  = item_addr;
                wdata_d = item_wdata;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CW'(1);
                if (bus_done) begin
                    if (seq_q == Q_RD)
                        shad_d[idx_q] = rd_data;
                    state_d = S_NEXT;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_NEXT: begin
                if (idx_q == last_idx) begin
                    state_d = S_IDLE;
                    if (seq_q == Q_RD) begin
                        r_d   = shad_q;
                        rdv_d = 1'b1;
                    end
                    if (seq_q == Q_INIT)
                        err_d = 1'b0;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_ISSUE;
                end
            end
        endcase

        // New pulses win over a same-cycle grant clear
        if (init_req)
            init_p_d = 1'b1;
        if (wr_req) begin
            wr_p_d  = 1'b1;
            wr_ct_d = ct_sel;
        end
        if (refresh_tick)
            rd_p_d = 1'b1;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            seq_q    <= Q_INIT;
            idx_q    <= 4'd0;
            cnt_q    <= '0;
            init_p_q <= 1'b0;
            wr_p_q   <= 1'b0;
            rd_p_q   <= 1'b0;
            wr_ct_q  <= 1'b0;
            err_q    <= 1'b0;
            rdv_q    <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 8'h00;
            snap_q   <= '{default: 8'h00};
            shad_q   <= '{default: 8'h00};
            r_q      <= '{default: 8'h00};
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            init_p_q <= init_p_d;
            wr_p_q   <= wr_p_d;
            rd_p_q   <= rd_p_d;
            wr_ct_q  <= wr_ct_d;
            err_q    <= err_d;
            rdv_q    <= rdv_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            snap_q   <= snap_d;
            shad_q   <= shad_d;
            r_q      <= r_d;
        end
    end

    // Bus fields come straight from the decode during ISSUE, then hold
    assign bus_start = (state_q == S_ISSUE);
    assign bus_rw    = bus_start ? item_rw    : rw_q;
    assign bus_addr  = bus_start ? item_addr  : addr_q;
    assign bus_wdata = bus_start ? item_wdata : wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign bus_err   = err_q;
    assign rd_valid  = rdv_q;

    assign r_seg   = r_q[0];
    assign r_min   = r_q[1];
    assign r_hora  = r_q[2];
    assign r_dia   = r_q[3];
    assign r_mes   = r_q[4];
    assign r_ano   = r_q[5];
    assign r_tseg  = r_q[6];
    assign r_tmin  = r_q[7];
    assign r_thora = r_q[8];

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Bench for rtc_bus_scheduler: transaction-level model of the expected
// bus items and read-back commits, checked against the DUT every cycle.
module tb_rtc_bus_scheduler;

    localparam int ENG_LAT = 4;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       init_req, wr_req, ct_sel, refresh_tick;
    logic [7:0] w_seg, w_min, w_hora, w_dia, w_mes, w_ano;
    logic [7:0] w_tseg, w_tmin, w_thora;
    logic       bus_done;
    logic [7:0] rd_data;
    logic       bus_start, bus_rw;
    logic [7:0] bus_addr, bus_wdata;
    logic [7:0] r_seg, r_min, r_hora, r_dia, r_mes, r_ano;
    logic [7:0] r_tseg, r_tmin, r_thora;
    logic       rd_valid, busy, bus_err;

    rtc_bus_scheduler dut (
        .CLK(CLK), .Reset(Reset),
        .init_req(init_req), .wr_req(wr_req), .ct_sel(ct_sel),
        .refresh_tick(refresh_tick),
        .w_seg(w_seg), .w_min(w_min), .w_hora(w_hora),
        .w_dia(w_dia), .w_mes(w_mes), .w_ano(w_ano),
        .w_tseg(w_tseg), .w_tmin(w_tmin), .w_thora(w_thora),
        .bus_done(bus_done), .rd_data(rd_data),
        .bus_start(bus_start), .bus_rw(bus_rw),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .r_seg(r_seg), .r_min(r_min), .r_hora(r_hora),
        .r_dia(r_dia), .r_mes(r_mes), .r_ano(r_ano),
        .r_tseg(r_tseg), .r_tmin(r_tmin), .r_thora(r_thora),
        .rd_valid(rd_valid), .busy(busy), .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    wire [71:0] r_all = {r_thora, r_tmin, r_tseg, r_ano, r_mes,
                         r_dia, r_hora, r_min, r_seg};

    int n_checks = 0;
    int n_pass   = 0;
    int n_start  = 0;
    int n_rdv    = 0;
    int n_rise   = 0;
    logic [7:0] rd_base = 8'h00;
    bit withhold = 1'b0;

    logic [16:0] q_txn [$];
    logic [71:0] q_r [$];

    task automatic chk(input string nm, input logic [71:0] act,
                       input logic [71:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Model: what each requested sequence must put on the bus
    task automatic push_txn(input bit rw, input logic [7:0] a,
                            input logic [7:0] d);
        q_txn.push_back({rw, a, d});
    endtask

    task automatic push_init();
        push_txn(1'b1, 8'h02, 8'h10);
        push_txn(1'b1, 8'h02, 8'h00);
    endtask

    task automatic push_clock(input logic [47:0] v);
        for (int i = 0; i < 6; i++)
            push_txn(1'b1, 8'h21 + 8'(i), v[8*i +: 8]);
    endtask

    task automatic push_timer(input logic [23:0] v);
        for (int i = 0; i < 3; i++)
            push_txn(1'b1, 8'h41 + 8'(i), v[8*i +: 8]);
    endtask

    task automatic push_read(input logic [7:0] base);
        logic [71:0] e;
        for (int i = 0; i < 6; i++)
            push_txn(1'b0, 8'h21 + 8'(i), 8'h00);
        for (int i = 0; i < 3; i++)
            push_txn(1'b0, 8'h41 + 8'(i), 8'h00);
        for (int i = 0; i < 9; i++)
            e[8*i +: 8] = base + 8'(i + 1);
        q_r.push_back(e);
    endtask

    function automatic logic [7:0] rd_val(input logic [7:0] a);
        if (a >= 8'h41) return rd_base + 8'd7 + (a - 8'h41);
        return rd_base + (a - 8'h20);
    endfunction

    // Bus-cycle engine: done ENG_LAT cycles after each start
    int eng_cnt = 0;
    initial begin
        bus_done = 1'b0;
        rd_data  = 8'h00;
        forever begin
            @(negedge CLK);
            bus_done = 1'b0;
            if (Reset) begin
                eng_cnt = 0;
            end else begin
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0 && !withhold) begin
                        bus_done = 1'b1;
                        rd_data  = rd_val(bus_addr);
                    end
                end
                if (bus_start) eng_cnt = ENG_LAT;
            end
        end
    end

    // Compare process
    initial begin
        logic [16:0] cur;
        logic [71:0] r_prev;
        bit outst;
        bit busy_prev;
        outst = 1'b0;
        busy_prev = 1'b0;
        r_prev = '0;
        cur = '0;
        forever begin
            @(posedge CLK);
            #1;
            if (Reset) begin
                outst = 1'b0;
                busy_prev = 1'b0;
                r_prev = r_all;
                continue;
            end
            if (busy && !busy_prev) n_rise++;
            busy_prev = busy;
            if (bus_start) begin
                n_start++;
                chk("start_expected", 72'(q_txn.size() != 0), 72'(1));
                if (q_txn.size() != 0) begin
                    cur = q_txn.pop_front();
                    chk("bus_rw", 72'(bus_rw), 72'(cur[16]));
                    chk("bus_addr", 72'(bus_addr), 72'(cur[15:8]));
                    if (cur[16])
                        chk("bus_wdata", 72'(bus_wdata), 72'(cur[7:0]));
                    outst = 1'b1;
                end
            end else if (outst) begin
                chk("hold_rw", 72'(bus_rw), 72'(cur[16]));
                chk("hold_addr", 72'(bus_addr), 72'(cur[15:8]));
                if (cur[16])
                    chk("hold_wdata", 72'(bus_wdata), 72'(cur[7:0]));
            end
            if (outst && bus_done) outst = 1'b0;
            if (rd_valid) begin
                n_rdv++;
                chk("rdv_expected", 72'(q_r.size() != 0), 72'(1));
                if (q_r.size() != 0)
                    chk("r_commit", r_all, q_r.pop_front());
            end else if (r_all !== r_prev) begin
                chk("r_stable", r_all, r_prev);
            end
            r_prev = r_all;
        end
    end

    task automatic pulse(input bit i, input bit w, input bit r);
        @(negedge CLK);
        init_req = i;
        wr_req = w;
        refresh_tick = r;
        @(negedge CLK);
        init_req = 1'b0;
        wr_req = 1'b0;
        refresh_tick = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        int q = 0;
        int n = 0;
        repeat (3) @(negedge CLK);
        while (q < 5 && n < budget) begin
            @(negedge CLK);
            n++;
            q = busy ? 0 : q + 1;
        end
        chk("seq_done_in_time", 72'(q >= 5), 72'(1));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, 72'(busy), 72'(0));
        chk({nm, "_start"}, 72'(bus_start), 72'(0));
        chk({nm, "_err"}, 72'(bus_err), 72'(0));
        chk({nm, "_rdv"}, 72'(rd_valid), 72'(0));
        chk({nm, "_bus"}, 72'({bus_rw, bus_addr, bus_wdata}), 72'(0));
        chk({nm, "_r"}, r_all, 72'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0, k, n;
        Reset = 1'b1;
        init_req = 1'b0; wr_req = 1'b0; ct_sel = 1'b0; refresh_tick = 1'b0;
        w_seg = 8'h45; w_min = 8'h30; w_hora = 8'h12;
        w_dia = 8'h15; w_mes = 8'h08; w_ano = 8'h16;
        w_tseg = 8'h11; w_tmin = 8'h22; w_thora = 8'h33;
        repeat (3) @(negedge CLK);
        chk_zero("reset");
        Reset = 1'b0;

        // Clock write
        ct_sel = 1'b1;
        push_clock({8'h16, 8'h08, 8'h15, 8'h12, 8'h30, 8'h45});
        pulse(1'b0, 1'b1, 1'b0);
        wait_quiet(500);
        chk("clk_starts", 72'(n_start), 72'(6));
        chk("clk_no_rdv", 72'(n_rdv), 72'(0));
        chk("clk_q_empty", 72'(q_txn.size()), 72'(0));

        // Refresh read returning 01..09
        rd_base = 8'h00;
        push_read(8'h00);
        pulse(1'b0, 1'b0, 1'b1);
        wait_quiet(500);
        chk("rd_rdv", 72'(n_rdv), 72'(1));
        chk("rd_seg_lit", 72'(r_seg), 72'(8'h01));
        chk("rd_thora_lit", 72'(r_thora), 72'(8'h09));
        chk("rd_starts", 72'(n_start), 72'(15));

        // Priority: init > timer write > read
        rd_base = 8'h10;
        ct_sel = 1'b0;
        push_init();
        push_timer({8'h33, 8'h22, 8'h11});
        push_read(8'h10);
        k = n_rise;
        pulse(1'b1, 1'b1, 1'b1);
        wait_quiet(1000);
        chk("prio_busy_periods", 72'(n_rise - k), 72'(3));
        chk("prio_tmin_lit", 72'(r_tmin), 72'(8'h18));
        chk("prio_q_empty", 72'(q_txn.size()), 72'(0));

        // Requests during busy merge; snapshot survives input changes
        rd_base = 8'h20;
        push_read(8'h20);
        push_timer({8'h33, 8'h22, 8'h11});
        s0 = n_start;
        k = n_rdv;
        pulse(1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge CLK);
        ct_sel = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge CLK);
        ct_sel = 1'b0;
        pulse(1'b0, 1'b1, 1'b0);
        n = 0;
        while (n_rdv == k && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("merge_rdv_seen", 72'(n_rdv - k), 72'(1));
        n = 0;
        while (!bus_start && n < 50) begin
            @(negedge CLK);
            n++;
        end
        w_tseg = 8'hEE; w_tmin = 8'hEE; w_thora = 8'hEE;
        wait_quiet(500);
        chk("merge_starts", 72'(n_start - s0), 72'(12));
        chk("merge_q_empty", 72'(q_txn.size()), 72'(0));

        // Timeout on a withheld done
        withhold = 1'b1;
        k = n_rdv;
        push_txn(1'b0, 8'h21, 8'h00);
        pulse(1'b0, 1'b0, 1'b1);
        wait_quiet(3000);
        chk("to_err", 72'(bus_err), 72'(1));
        chk("to_busy", 72'(busy), 72'(0));
        chk("to_no_rdv", 72'(n_rdv - k), 72'(0));
        chk("to_r_seg_lit", 72'(r_seg), 72'(8'h21));
        chk("to_q_empty", 72'(q_txn.size()), 72'(0));
        withhold = 1'b0;

        // Init clears the error
        push_init();
        pulse(1'b1, 1'b0, 1'b0);
        wait_quiet(500);
        chk("init_clr_err", 72'(bus_err), 72'(0));

        // Reset mid-read at item 4
        rd_base = 8'h30;
        push_read(8'h30);
        s0 = n_start;
        pulse(1'b0, 1'b0, 1'b1);
        n = 0;
        while (n_start < s0 + 4 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        chk("mid_item4_reached", 72'(n_start - s0), 72'(4));
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        chk_zero("mid_reset");
        q_txn.delete();
        q_r.delete();
        repeat (2) @(negedge CLK);
        Reset = 1'b0;
        repeat (50) @(negedge CLK);
        chk("mid_no_start", 72'(n_start - s0), 72'(4));
        chk("mid_busy", 72'(busy), 72'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
